// File: rtl/vtage_pkg.sv
// Shared types and default sizing for the VTAGE value-table write path.
package vtage_pkg;

  localparam int unsigned VT_STORAGE_SIZE = 2048;
  localparam int unsigned VT_DATA_WIDTH   = 32;
  localparam int unsigned VT_QUEUE_DEPTH  = 8;
  localparam int unsigned VT_ADDR_WIDTH   = $clog2(VT_STORAGE_SIZE);

  typedef struct packed {
    logic [VT_ADDR_WIDTH-1:0] addr;
    logic [VT_DATA_WIDTH-1:0] data;
  } vt_update_t;

  typedef enum logic {
    INIT = 1'b0,
    RUN  = 1'b1
  } vt_wr_state_e;

endpackage

// File: rtl/vtage_update_fifo.sv
// Two-in/two-out circular queue of packed {addr, data} updates, oldest entry at head.
module vtage_update_fifo #(
  parameter int unsigned Depth = 8,
  parameter int unsigned Width = 43,
  localparam int unsigned IdxW = $clog2(Depth),
  localparam int unsigned CntW = $clog2(Depth) + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             push_a,
  input  logic             push_b,
  input  logic [Width-1:0] din_a,
  input  logic [Width-1:0] din_b,
  input  logic             drain,
  output logic [Width-1:0] head,
  output logic [Width-1:0] head_next,
  output logic [CntW-1:0]  count,
  output logic [1:0]       pop_cnt,
  output logic             ready
);

  logic [Width-1:0] mem_q [Depth];
  logic [IdxW-1:0]  head_q, tail_q, tail_b;
  logic [CntW-1:0]  count_q;
  logic [1:0]       push_cnt;

  always_comb begin
    push_cnt = {1'b0, push_a} + {1'b0, push_b};
    // b lands right behind a when both arrive, otherwise it takes the tail itself
    tail_b   = push_a ? tail_q + 1'b1 : tail_q;
    if (!drain) begin
      pop_cnt = 2'd0;
    end else if (count_q >= CntW'(2)) begin
      pop_cnt = 2'd2;
    end else begin
      pop_cnt = count_q[1:0];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
      for (int i = 0; i < Depth; i++) begin
        mem_q[i] <= '0;
      end
    end else if (flush) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      if (push_a) mem_q[tail_q] <= din_a;
      if (push_b) mem_q[tail_b] <= din_b;
      tail_q  <= tail_q + IdxW'(push_cnt);
      head_q  <= head_q + IdxW'(pop_cnt);
      count_q <= count_q + CntW'(push_cnt) - CntW'(pop_cnt);
    end
  end

  assign head      = mem_q[head_q];
  assign head_next = mem_q[head_q + 1'b1];
  assign count     = count_q;
  assign ready     = (count_q <= CntW'(Depth - 2));

endmodule

// File: rtl/vtage_vt_writer.sv
// VTAGE value-table write front end: zeroing sweep after reset, then in-order drain of
// queued training updates onto the table's two write ports.
module vtage_vt_writer
  import vtage_pkg::*;
#(
  parameter int unsigned P_STORAGE_SIZE = VT_STORAGE_SIZE,
  parameter int unsigned P_DATA_WIDTH   = VT_DATA_WIDTH,
  parameter int unsigned P_QUEUE_DEPTH  = VT_QUEUE_DEPTH,
  localparam int unsigned LP_ADDRESS_WIDTH = $clog2(P_STORAGE_SIZE),
  localparam int unsigned LP_CNT_WIDTH     = $clog2(P_QUEUE_DEPTH) + 1
) (
  input  logic                        clk_i,
  input  logic                        rst_i,
  input  logic                        init_req_i,
  input  logic                        upa_valid_i,
  input  logic [LP_ADDRESS_WIDTH-1:0] upa_addr_i,
  input  logic [P_DATA_WIDTH-1:0]     upa_data_i,
  input  logic                        upb_valid_i,
  input  logic [LP_ADDRESS_WIDTH-1:0] upb_addr_i,
  input  logic [P_DATA_WIDTH-1:0]     upb_data_i,
  output logic                        up_ready_o,
  output logic                        wra_valid_o,
  output logic [LP_ADDRESS_WIDTH-1:0] wra_addr_o,
  output logic [P_DATA_WIDTH-1:0]     wra_data_o,
  output logic                        wrb_valid_o,
  output logic [LP_ADDRESS_WIDTH-1:0] wrb_addr_o,
  output logic [P_DATA_WIDTH-1:0]     wrb_data_o,
  output logic                        init_done_o,
  output logic [LP_CNT_WIDTH-1:0]     count_o
);

  localparam int unsigned EntryW = LP_ADDRESS_WIDTH + P_DATA_WIDTH;

  vt_wr_state_e                state_q, state_d;
  logic [LP_ADDRESS_WIDTH-1:0] ptr_q, ptr_d;

  logic              ready;
  logic              push_a, push_b;
  logic              drain;
  logic [1:0]        pop_cnt;
  logic [EntryW-1:0] head, head_next;

  logic [LP_ADDRESS_WIDTH-1:0] head_addr, next_addr;
  logic [P_DATA_WIDTH-1:0]     head_data, next_data;

  assign push_a = upa_valid_i & ready;
  assign push_b = upb_valid_i & ready;
  // A re-init request wipes the queue, so nothing from it is written that cycle either
  assign drain  = (state_q == RUN) & ~init_req_i;

  vtage_update_fifo #(
    .Depth (P_QUEUE_DEPTH),
    .Width (EntryW)
  ) u_fifo (
    .clk       (clk_i),
    .rst       (rst_i),
    .flush     (init_req_i),
    .push_a    (push_a),
    .push_b    (push_b),
    .din_a     ({upa_addr_i, upa_data_i}),
    .din_b     ({upb_addr_i, upb_data_i}),
    .drain     (drain),
    .head      (head),
    .head_next (head_next),
    .count     (count_o),
    .pop_cnt   (pop_cnt),
    .ready     (ready)
  );

  assign head_addr = head[P_DATA_WIDTH +: LP_ADDRESS_WIDTH];
  assign head_data = head[P_DATA_WIDTH-1:0];
  assign next_addr = head_next[P_DATA_WIDTH +: LP_ADDRESS_WIDTH];
  assign next_data = head_next[P_DATA_WIDTH-1:0];

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    if (init_req_i) begin
      state_d = INIT;
      ptr_d   = '0;
    end else if (state_q == INIT) begin
      ptr_d = ptr_q + LP_ADDRESS_WIDTH'(2);
      if (ptr_q == LP_ADDRESS_WIDTH'(P_STORAGE_SIZE - 2)) begin
        state_d = RUN;
      end
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= INIT;
      ptr_q   <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
    end
  end

  always_comb begin
    wra_valid_o = 1'b0;
    wra_addr_o  = '0;
    wra_data_o  = '0;
    wrb_valid_o = 1'b0;
    wrb_addr_o  = '0;
    wrb_data_o  = '0;
    if (state_q == INIT) begin
      // Sweep pair is held off while reset is asserted so the table sees no writes
      if (!rst_i) begin
        wra_valid_o = 1'b1;
        wra_addr_o  = ptr_q;
        wrb_valid_o = 1'b1;
        wrb_addr_o  = ptr_q + 1'b1;
      end
    end else begin
      wra_addr_o  = head_addr;
      wra_data_o  = head_data;
      wrb_addr_o  = next_addr;
      wrb_data_o  = next_data;
      wrb_valid_o = (pop_cnt == 2'd2);
      // Same-address pair: only the younger (port b) value is written
      wra_valid_o = (pop_cnt != 2'd0) && !((pop_cnt == 2'd2) && (head_addr == next_addr));
    end
  end

  assign up_ready_o  = ready;
  assign init_done_o = (state_q == RUN);

endmodule
